// File: rtl/mmio_access_ctrl.sv
// mmio_access_ctrl
//   Memory-access controller between the CPU MEM stage and IMEM, DMEM and
//   NUM_CH memory-mapped serial channels. It decodes the address, generates
//   byte enables and lane-replicated store data, and aligns and extends load
//   data with a one-cycle load latency. It stalls the MEM stage while a
//   channel transmit is blocked, and drops that transmit after TIMEOUT wait
//   cycles.
//
//   Optional feature (macro MMIO_CYCLE_COUNTER_EN): a free-running CNT_W-bit
//   cycle counter. It reads at IO channel 0 register 3 (0x8000_000C), and any
//   store to that address clears it.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/we/size/signed        MEM-stage access request
//   req_addr, req_wdata             byte address, LSB-justified store data
//   stall                           hold MEM stage (request stays stable)
//   resp_valid, rdata               load response, one cycle after accept
//   err_misalign, err_timeout       one-cycle error pulses
//   imem_we, dmem_we                per-byte write enables
//   mem_addr, mem_wdata             word address and replicated store data
//   dmem_rdata                      DMEM synchronous read data
//   io_tx_valid/data/ready          channel transmit handshake
//   io_rx_valid/data/ready          channel receive handshake (ready = pop)
module mmio_access_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  err_misalign,
    output logic                  err_timeout,
    output logic [3:0]            imem_we,
    output logic [3:0]            dmem_we,
    output logic [29:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           dmem_rdata,
    output logic [NUM_CH-1:0]     io_tx_valid,
    output logic [7:0]            io_tx_data,
    input  logic [NUM_CH-1:0]     io_tx_ready,
    input  logic [NUM_CH-1:0]     io_rx_valid,
    input  logic [8*NUM_CH-1:0]   io_rx_data,
    output logic [NUM_CH-1:0]     io_rx_ready
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_TX_WAIT = 1'b1} state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_en = 4'b0001 << off;
            2'd1:    byte_en = 4'b0011 << {off[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            default: misaligned = (off != 2'd0);
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    lane_rep = {4{d[7:0]}};
            2'd1:    lane_rep = {2{d[15:0]}};
            default: lane_rep = d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    load_align = {{24{sgn & b[7]}}, b};
            2'd1:    load_align = {{16{sgn & h[15]}}, h};
            default: load_align = word;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [15:0]        wcnt_q, wcnt_d;
    logic [CH_W-1:0]    ch_q;
    logic [7:0]         tx_byte_q;
    logic               resp_valid_q, rsp_dmem_q, mis_q;
    logic [31:0]        io_word_q;
    logic [1:0]         off_q, size_q;
    logic               sgn_q;
    logic               err_misalign_q, err_timeout_q;

    logic [CH_W-1:0]    ch_s, ch_sel_s;
    logic [1:0]         reg_s;
    logic               ch_ok_s, is_io_s, mis_s, idle_req_s, acc_s;
    logic               tx_store_s, tx_block_s, tx_now_s, wait_ready_s, wait_drop_s;
    logic               mem_store_s, rx_pop_s;
    logic [3:0]         be_s;
    logic [NUM_CH-1:0]  oh_s, oh_q_s;
    logic [31:0]        io_word_s;

    assign ch_s     = req_addr[4 +: CH_W];
    assign reg_s    = req_addr[3:2];
    assign ch_ok_s  = (int'(ch_s) < NUM_CH);
    // Out-of-range channels are forced to 0 so per-channel selects stay in bounds.
    assign ch_sel_s = ch_ok_s ? ch_s : {CH_W{1'b0}};
    assign oh_s     = NUM_CH'(1'b1) << ch_sel_s;
    assign oh_q_s   = NUM_CH'(1'b1) << ch_q;
    assign is_io_s  = req_addr[31];
    assign mis_s    = misaligned(req_size, req_addr[1:0]);
    assign be_s     = byte_en(req_size, req_addr[1:0]);

    // New accesses are decoded only in IDLE; in TX_WAIT the held request is the pending transmit.
    assign idle_req_s   = req_valid & (state_q == ST_IDLE);
    assign tx_store_s   = idle_req_s & req_we & is_io_s & ch_ok_s & (reg_s == 2'd2) & ~mis_s;
    assign tx_block_s   = tx_store_s & ~io_tx_ready[ch_sel_s];
    assign tx_now_s     = tx_store_s & io_tx_ready[ch_sel_s];
    assign acc_s        = idle_req_s & ~tx_block_s;
    assign wait_ready_s = (state_q == ST_TX_WAIT) & io_tx_ready[ch_q];
    assign wait_drop_s  = (state_q == ST_TX_WAIT) & ~io_tx_ready[ch_q] & (wcnt_q == 16'(TIMEOUT));
    assign mem_store_s  = acc_s & ~mis_s & req_we & ~is_io_s;
    assign rx_pop_s     = acc_s & ~mis_s & ~req_we & is_io_s & ch_ok_s & (reg_s == 2'd1)
                          & io_rx_valid[ch_sel_s];

    assign stall       = tx_block_s | ((state_q == ST_TX_WAIT) & ~wait_ready_s & ~wait_drop_s);
    assign imem_we     = (mem_store_s & req_addr[29]) ? be_s : 4'h0;
    assign dmem_we     = (mem_store_s & req_addr[28]) ? be_s : 4'h0;
    assign mem_addr    = req_addr[31:2];
    assign mem_wdata   = lane_rep(req_size, req_wdata);
    assign io_tx_data  = (state_q == ST_TX_WAIT) ? tx_byte_q : req_wdata[7:0];
    assign io_tx_valid = tx_now_s ? oh_s : (wait_ready_s ? oh_q_s : {NUM_CH{1'b0}});
    assign io_rx_ready = rx_pop_s ? oh_s : {NUM_CH{1'b0}};

    assign resp_valid   = resp_valid_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;
    // DMEM data only arrives in the response cycle, so alignment is applied after the register.
    assign rdata = (resp_valid_q & ~mis_q)
                   ? load_align(rsp_dmem_q ? dmem_rdata : io_word_q, size_q, off_q, sgn_q)
                   : 32'h0;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [CNT_W-1:0]    cyc_q;
    logic [CNT_W+31:0]   cyc_ext_s;
    logic [31:0]         cyc_rd_s;
    assign cyc_ext_s = {32'h0, cyc_q};
    assign cyc_rd_s  = cyc_ext_s[31:0];

    // Free-running cycle counter, cleared by a store to channel 0 register 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= {CNT_W{1'b0}};
        end else if (acc_s & ~mis_s & req_we & is_io_s & ch_ok_s & (ch_s == {CH_W{1'b0}})
                     & (reg_s == 2'd3)) begin
            cyc_q <= {CNT_W{1'b0}};
        end else begin
            cyc_q <= cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_cnt_w_s;
    assign unused_cnt_w_s = ^CNT_W;
`endif

    // IO register read value for the addressed channel.
    always_comb begin
        io_word_s = 32'h0;
        if (ch_ok_s) begin
            case (reg_s)
                2'd0: io_word_s = {30'h0, io_rx_valid[ch_sel_s], io_tx_ready[ch_sel_s]};
                2'd1: io_word_s = io_rx_valid[ch_sel_s]
                                  ? {24'h0, io_rx_data[{ch_sel_s, 3'b000} +: 8]} : 32'h0;
                2'd3: begin
`ifdef MMIO_CYCLE_COUNTER_EN
                    io_word_s = (ch_sel_s == {CH_W{1'b0}}) ? cyc_rd_s : 32'h0;
`else
                    io_word_s = 32'h0;
`endif
                end
                default: io_word_s = 32'h0;
            endcase
        end else begin
            io_word_s = 32'h0;
        end
    end

    // Transmit FSM next state and wait-cycle counter.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_block_s) begin
                    state_d = ST_TX_WAIT;
                    wcnt_d  = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                    wcnt_d  = 16'd0;
                end
            end
            ST_TX_WAIT: begin
                if (wait_ready_s | wait_drop_s) begin
                    state_d = ST_IDLE;
                    wcnt_d  = 16'd0;
                end else begin
                    state_d = ST_TX_WAIT;
                    wcnt_d  = wcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 16'd0;
            end
        endcase
    end

    // State, pending transmit and load-response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= 16'd0;
            ch_q           <= {CH_W{1'b0}};
            tx_byte_q      <= 8'h0;
            resp_valid_q   <= 1'b0;
            rsp_dmem_q     <= 1'b0;
            mis_q          <= 1'b0;
            io_word_q      <= 32'h0;
            off_q          <= 2'd0;
            size_q         <= 2'd0;
            sgn_q          <= 1'b0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            if (tx_block_s) begin
                ch_q      <= ch_sel_s;
                tx_byte_q <= req_wdata[7:0];
            end
            resp_valid_q   <= acc_s & ~req_we;
            if (acc_s & ~req_we) begin
                rsp_dmem_q <= ~is_io_s & req_addr[28];
                io_word_q  <= is_io_s ? io_word_s : 32'h0;
                mis_q      <= mis_s;
                off_q      <= req_addr[1:0];
                size_q     <= req_size;
                sgn_q      <= req_signed;
            end
            err_misalign_q <= acc_s & mis_s;
            err_timeout_q  <= wait_drop_s;
        end
    end

endmodule
